// File: rtl/cmm_pkg.sv
// rtl/cmm_pkg.sv - shared types and constants for the 2x2 complex matrix-product engine
package cmm_pkg;

  localparam int WIDTH = 19;
  localparam int FRAC  = 16;
  localparam int ACC_W = 2 * WIDTH + 2;

  typedef logic signed [WIDTH-1:0] elem_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    STREAM,
    DONE
  } state_t;

  localparam acc_t ELEM_MAX = (acc_t'(1) <<< (WIDTH - 1)) - acc_t'(1);
  localparam acc_t ELEM_MIN = -(acc_t'(1) <<< (WIDTH - 1));

endpackage

// File: rtl/cmm2x2_engine_if.sv
// rtl/cmm2x2_engine_if.sv - load and result-stream signal bundle for cmm2x2_engine
interface cmm2x2_engine_if;

  cmm_pkg::elem_t matrix_in;
  logic           imag;
  logic           row;
  logic           col;
  logic           operand;
  logic           in_ready;
  logic           in_finished;
  logic           done;
  cmm_pkg::elem_t result_out;
  logic           result_row;
  logic           result_col;
  logic           result_imag;
  logic           result_valid;

  modport master (
    output matrix_in, imag, row, col, operand, in_ready, in_finished,
    input  done, result_out, result_row, result_col, result_imag, result_valid
  );

  modport slave (
    input  matrix_in, imag, row, col, operand, in_ready, in_finished,
    output done, result_out, result_row, result_col, result_imag, result_valid
  );

endinterface

// File: rtl/cmm_complex_mac.sv
// rtl/cmm_complex_mac.sv - complex multiply with optional second product, rescale and reduce
// CMM_SATURATE_EN: saturate the reduced result instead of two's-complement wrap.
module cmm_complex_mac
  import cmm_pkg::*;
(
  input  elem_t ar0,
  input  elem_t ai0,
  input  elem_t br0,
  input  elem_t bi0,
  input  elem_t ar1,
  input  elem_t ai1,
  input  elem_t br1,
  input  elem_t bi1,
  input  logic  add_en,
  output elem_t re,
  output elem_t im
);

  acc_t p_re0, p_im0, p_re1, p_im1;
  acc_t sum_re, sum_im, sh_re, sh_im;

  function automatic acc_t mul(input elem_t a, input elem_t b);
    return acc_t'(a) * acc_t'(b);
  endfunction

  function automatic elem_t reduce(input acc_t v);
`ifdef CMM_SATURATE_EN
    if (v > ELEM_MAX) return ELEM_MAX[WIDTH-1:0];
    if (v < ELEM_MIN) return ELEM_MIN[WIDTH-1:0];
    return v[WIDTH-1:0];
`else
    return v[WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    p_re0  = mul(ar0, br0) - mul(ai0, bi0);
    p_im0  = mul(ar0, bi0) + mul(ai0, br0);
    p_re1  = '0;
    p_im1  = '0;
    if (add_en) begin
      p_re1 = mul(ar1, br1) - mul(ai1, bi1);
      p_im1 = mul(ar1, bi1) + mul(ai1, br1);
    end
    sum_re = p_re0 + p_re1;
    sum_im = p_im0 + p_im1;
    // Arithmetic shift floors toward minus infinity.
    sh_re  = sum_re >>> FRAC;
    sh_im  = sum_im >>> FRAC;
  end

  assign re = reduce(sh_re);
  assign im = reduce(sh_im);

endmodule

// File: rtl/cmm2x2_engine.sv
// rtl/cmm2x2_engine.sv - 2x2 complex matrix product: word-addressed load, 4-cycle compute, 8-word stream
// CMM_SATURATE_EN selects saturating result reduction inside cmm_complex_mac.
module cmm2x2_engine
  import cmm_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  elem_t matrix_in,
  input  logic  imag,
  input  logic  row,
  input  logic  col,
  input  logic  operand,
  input  logic  in_ready,
  input  logic  in_finished,
  output logic  done,
  output elem_t result_out,
  output logic  result_row,
  output logic  result_col,
  output logic  result_imag,
  output logic  result_valid
);

  elem_t  mem   [2][2][2][2];
  elem_t  c_reg [2][2][2];
  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic   in_ready_q;
  logic   start;
  logic   wr_en;
  logic   ci, cj;
  elem_t  mac_re, mac_im;

  assign start = in_finished || (in_ready_q && !in_ready);
  assign wr_en = in_ready && (state == IDLE || state == DONE);
  assign ci    = cnt[1];
  assign cj    = cnt[0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COMPUTE;
          cnt_nxt   = 3'd0;
        end
      end
      COMPUTE: begin
        if (cnt == 3'd3) begin
          state_nxt = STREAM;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      STREAM: begin
        if (cnt == 3'd7) begin
          state_nxt = DONE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cij = Ai0*B0j + Ai1*B1j, one element per COMPUTE cycle.
  cmm_complex_mac u_mac (
    .ar0    (mem[0][ci][0][0]),
    .ai0    (mem[0][ci][0][1]),
    .br0    (mem[1][0][cj][0]),
    .bi0    (mem[1][0][cj][1]),
    .ar1    (mem[0][ci][1][0]),
    .ai1    (mem[0][ci][1][1]),
    .br1    (mem[1][1][cj][0]),
    .bi1    (mem[1][1][cj][1]),
    .add_en (1'b1),
    .re     (mac_re),
    .im     (mac_im)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      in_ready_q   <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result_out   <= '0;
      result_row   <= 1'b0;
      result_col   <= 1'b0;
      result_imag  <= 1'b0;
      for (int o = 0; o < 2; o++)
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            for (int i = 0; i < 2; i++) begin
              mem[o][r][c][i] <= '0;
              if (o == 0) c_reg[r][c][i] <= '0;
            end
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      in_ready_q <= in_ready;

      if (wr_en) mem[operand][row][col][imag] <= matrix_in;

      if (state == COMPUTE) begin
        c_reg[ci][cj][0] <= mac_re;
        c_reg[ci][cj][1] <= mac_im;
      end

      result_valid <= (state == STREAM);
      if (state == STREAM) begin
        result_out  <= c_reg[cnt[2]][cnt[1]][cnt[0]];
        result_row  <= cnt[2];
        result_col  <= cnt[1];
        result_imag <= cnt[0];
      end

      // done rises after the last word and falls on the next write or start.
      if (state == DONE) done <= !in_ready;
      else if (state == IDLE && (in_ready || start)) done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmm2x2_engine.sv
// tb/tb_cmm2x2_engine.sv - scoreboard bench for cmm2x2_engine (honours CMM_SATURATE_EN)
module tb_cmm2x2_engine;
  import cmm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmm2x2_engine_if bus ();

  cmm2x2_engine dut (
    .clk          (clk),
    .reset        (reset),
    .matrix_in    (bus.matrix_in),
    .imag         (bus.imag),
    .row          (bus.row),
    .col          (bus.col),
    .operand      (bus.operand),
    .in_ready     (bus.in_ready),
    .in_finished  (bus.in_finished),
    .done         (bus.done),
    .result_out   (bus.result_out),
    .result_row   (bus.result_row),
    .result_col   (bus.result_col),
    .result_imag  (bus.result_imag),
    .result_valid (bus.result_valid)
  );

  typedef struct {
    int val;
    int tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   m[2][2][2][2];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int r, input int c, input int im);
    longint acc, s, ar, ai, br, bi;
    acc = 0;
    for (int k = 0; k < 2; k++) begin
      ar = m[0][r][k][0];
      ai = m[0][r][k][1];
      br = m[1][k][c][0];
      bi = m[1][k][c][1];
      if (im == 0) acc += ar * br - ai * bi;
      else         acc += ar * bi + ai * br;
    end
    s = acc >>> FRAC;
`ifdef CMM_SATURATE_EN
    if (s > 262143)  s = 262143;
    if (s < -262144) s = -262144;
`else
    s = s & 64'sh7FFFF;
    if (s >= 262144) s -= 524288;
`endif
    return int'(s);
  endfunction

  function automatic int rnd_elem();
    return int'($urandom_range(0, 524287)) - 262144;
  endfunction

  task automatic clear_m();
    for (int o = 0; o < 2; o++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          for (int i = 0; i < 2; i++) m[o][r][c][i] = 0;
  endtask

  task automatic push_exp(input int idx, input int val);
    exp_t x;
    x.val = val;
    x.tag = idx;
    sb.push_back(x);
  endtask

  task automatic push_model(input int from_idx);
    for (int idx = from_idx; idx < 8; idx++)
      push_exp(idx, model(idx >> 2, (idx >> 1) & 1, idx & 1));
  endtask

  task automatic wr(input int op, input int r, input int c, input int im, input int val, input bit fin);
    bus.operand     = op[0];
    bus.row         = r[0];
    bus.col         = c[0];
    bus.imag        = im[0];
    bus.matrix_in   = elem_t'(val);
    bus.in_ready    = 1'b1;
    bus.in_finished = fin;
    @(posedge clk);
    #1;
    bus.in_finished = 1'b0;
  endtask

  task automatic load_all(input bit fin_last);
    for (int o = 0; o < 2; o++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          for (int i = 0; i < 2; i++)
            wr(o, r, c, i, m[o][r][c][i], fin_last && o == 1 && r == 1 && c == 1 && i == 1);
  endtask

  task automatic start_by_drop();
    bus.in_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic start_by_finish();
    bus.in_ready    = 1'b0;
    bus.in_finished = 1'b1;
    @(posedge clk);
    #1;
    bus.in_finished = 1'b0;
  endtask

  // Called at #1 after the start edge N; checks first word at N+5 and done at N+13.
  task automatic run_wait(input string tag);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      if (k == 4)  check({tag, "_valid_before_first"}, bus.result_valid, 0);
      if (k == 5)  check({tag, "_valid_first"}, bus.result_valid, 1);
      if (k == 12) check({tag, "_done_early"}, bus.done, 0);
      if (k == 13) check({tag, "_done"}, bus.done, 1);
    end
    check({tag, "_words_left"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (bus.result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_word", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("result_word", int'($signed(bus.result_out)), e.val);
        check("result_tag", int'({bus.result_row, bus.result_col, bus.result_imag}), e.tag);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.operand     = 1'b0;
    bus.row         = 1'b0;
    bus.col         = 1'b0;
    bus.imag        = 1'b0;
    bus.in_finished = 1'b0;
    bus.in_ready    = 1'b1;
    bus.matrix_in   = elem_t'(12345);
    @(posedge clk);
    bus.operand     = 1'b1;
    @(posedge clk);
    #1;
    check("reset_done", bus.done, 0);
    check("reset_valid", bus.result_valid, 0);
    check("reset_result", int'($signed(bus.result_out)), 0);
    bus.in_ready = 1'b0;
    reset        = 1'b0;
    @(posedge clk);
    #1;
    check("idle_valid", bus.result_valid, 0);

    // All-zero storage streams zeros.
    clear_m();
    push_model(0);
    start_by_finish();
    run_wait("zero");

    // A = I: result equals B.
    clear_m();
    m[0][0][0][0] = 65536;
    m[0][1][1][0] = 65536;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 2; i++) m[1][r][c][i] = rnd_elem();
    for (int idx = 0; idx < 8; idx++)
      push_exp(idx, m[1][idx >> 2][(idx >> 1) & 1][idx & 1]);
    load_all(1'b1);
    bus.in_ready = 1'b0;
    run_wait("ident");

    // Fixed vector, started by in_ready falling.
    m[0][0][0][0] = 52088;   m[0][0][0][1] = 79805;
    m[0][0][1][0] = -24797;  m[0][0][1][1] = 58972;
    m[0][1][0][0] = 118476;  m[0][1][0][1] = 8055;
    m[0][1][1][0] = -114502; m[0][1][1][1] = 49719;
    m[1][0][0][0] = 97716;   m[1][0][0][1] = 23084;
    m[1][0][1][0] = -41710;  m[1][0][1][1] = 106908;
    m[1][1][0][0] = -71729;  m[1][1][0][1] = 85556;
    m[1][1][1][0] = -3769;   m[1][1][1][1] = 53804;
    push_exp(0, -292);
    push_model(1);
    load_all(1'b0);
    start_by_drop();
    run_wait("vector");

    // Overflow of C00re.
    clear_m();
    m[0][0][0][0] = 196608;
    m[1][0][0][0] = 196608;
`ifdef CMM_SATURATE_EN
    push_exp(0, 262143);
`else
    push_exp(0, 65536);
`endif
    push_model(1);
    load_all(1'b1);
    bus.in_ready = 1'b0;
    run_wait("overflow");

    // Rewrite: 100 then 200 to A00re; first write clears done.
    check("done_held", bus.done, 1);
    clear_m();
    m[1][0][0][0] = 65536;
    m[1][1][1][0] = 65536;
    m[0][0][0][0] = 200;
    m[0][1][0][1] = -777;
    m[0][0][1][1] = 4242;
    wr(0, 0, 0, 0, 100, 1'b0);
    check("done_cleared", bus.done, 0);
    push_exp(0, 200);
    push_model(1);
    load_all(1'b0);
    start_by_drop();
    run_wait("rewrite");

    // Reset after three streamed words.
    for (int o = 0; o < 2; o++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          for (int i = 0; i < 2; i++) m[o][r][c][i] = rnd_elem();
    push_model(0);
    load_all(1'b1);
    bus.in_ready = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1;
    check("midstream_words_left", sb.size(), 5);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("abort_valid", bus.result_valid, 0);
    check("abort_done", bus.done, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("post_abort_done", bus.done, 0);
      check("post_abort_valid", bus.result_valid, 0);
    end
    clear_m();
    push_model(0);
    start_by_finish();
    run_wait("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
